// File: rtl/flit_arb_mux_pkg.sv
// Shared constants and helpers for the flit arbitration multiplexer.
package flit_arb_mux_pkg;

    localparam int FLIT_ARB_EXT = 0;
    localparam int FLIT_ARB_RR  = 1;

    // Select width; a single-channel mux still carries a 1-bit select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flit_arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, wrapping at IN_NUM.
module flit_rr_arbiter
    import flit_arb_mux_pkg::*;
#(
    parameter int IN_NUM    = 4,
    parameter int SEL_WIDTH = sel_w(IN_NUM)
) (
    input  logic [SEL_WIDTH-1:0] i_ptr,
    input  logic [IN_NUM-1:0]    i_req,
    output logic [IN_NUM-1:0]    o_grant,
    output logic [SEL_WIDTH-1:0] o_idx
);

    localparam logic [SEL_WIDTH:0] N_W = (SEL_WIDTH+1)'(IN_NUM);

    logic [SEL_WIDTH:0]   w_sum;
    logic [SEL_WIDTH-1:0] w_idx;

    // Scan farthest offset first so the nearest requester is the last writer.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = IN_NUM-1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (SEL_WIDTH+1)'(k);
            if (w_sum >= N_W) w_sum = w_sum - N_W;
            w_idx = w_sum[SEL_WIDTH-1:0];
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/flit_arb_mux.sv
// Registered N:1 flit mux with valid/ready, packet locking and external or round-robin select.
module flit_arb_mux
    import flit_arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_NUM     = 4,
    parameter int SEL_WIDTH  = sel_w(IN_NUM),
    parameter int RR_MODE    = FLIT_ARB_RR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IN_NUM*DATA_WIDTH-1:0] in_data,
    input  logic [IN_NUM-1:0]            in_valid,
    input  logic [IN_NUM-1:0]            in_tail,
    output logic [IN_NUM-1:0]            in_ready,
    input  logic [SEL_WIDTH-1:0]         ext_sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic                         out_tail,
    output logic [SEL_WIDTH-1:0]         out_sel,
    input  logic                         out_ready,
    output logic                         locked
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_tail;
    logic [SEL_WIDTH-1:0]  r_out_sel;
    logic                  r_locked;
    logic [SEL_WIDTH-1:0]  r_lock_ch;
    logic [SEL_WIDTH-1:0]  r_rr_ptr;

    logic                  w_load_en;
    logic [IN_NUM-1:0]     w_rr_grant;
    logic [SEL_WIDTH-1:0]  w_rr_idx;
    logic [SEL_WIDTH-1:0]  w_cand;
    logic [IN_NUM-1:0]     w_cand_oh;
    logic [IN_NUM-1:0]     w_grant;
    logic                  w_xfer;
    logic                  w_tail;
    logic [DATA_WIDTH-1:0] w_flit;

    assign w_load_en = !r_out_valid || out_ready;

    generate
        if (RR_MODE == FLIT_ARB_RR) begin : g_rr
            flit_rr_arbiter #(
                .IN_NUM    (IN_NUM),
                .SEL_WIDTH (SEL_WIDTH)
            ) u_rr (
                .i_ptr   (r_rr_ptr),
                .i_req   (in_valid),
                .o_grant (w_rr_grant),
                .o_idx   (w_rr_idx)
            );
        end else begin : g_ext
            assign w_rr_grant = '0;
            assign w_rr_idx   = '0;
        end
    endgenerate

    // An out-of-range ext_sel decodes to no candidate at all.
    always_comb begin
        w_cand    = '0;
        w_cand_oh = '0;
        if (r_locked)                    w_cand = r_lock_ch;
        else if (RR_MODE == FLIT_ARB_RR) w_cand = w_rr_idx;
        else                             w_cand = ext_sel;
        for (int i = 0; i < IN_NUM; i++)
            w_cand_oh[i] = (w_cand == SEL_WIDTH'(i));
        if (!r_locked && RR_MODE == FLIT_ARB_RR) w_cand_oh = w_rr_grant;
    end

    assign w_grant  = (reset || !w_load_en) ? '0 : (w_cand_oh & in_valid);
    assign in_ready = w_grant;
    assign w_xfer   = |w_grant;
    assign w_tail   = |(w_grant & in_tail);

    always_comb begin
        w_flit = '0;
        for (int i = 0; i < IN_NUM; i++)
            if (w_grant[i]) w_flit = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_tail  <= 1'b0;
            r_out_sel   <= '0;
            r_locked    <= 1'b0;
            r_lock_ch   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_flit;
                r_out_tail <= w_tail;
                r_out_sel  <= w_cand;
                r_locked   <= !w_tail;
                if (!w_tail) r_lock_ch <= w_cand;
                if (RR_MODE == FLIT_ARB_RR && w_tail)
                    r_rr_ptr <= (w_cand == SEL_WIDTH'(IN_NUM-1)) ? '0 : w_cand + SEL_WIDTH'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_tail  = r_out_tail;
    assign out_sel   = r_out_sel;
    assign locked    = r_locked;

endmodule

// File: tb/tb_flit_arb_mux.sv
// Bench for flit_arb_mux: directed table in RR mode, ext-select sequence, random run vs. scoreboard.
module tb_flit_arb_mux;

    localparam int DW = 32;
    localparam int NA = 4;
    localparam int NB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: round-robin, 4 channels
    logic            a_rst;
    logic [NA*DW-1:0] a_data;
    logic [NA-1:0]   a_valid, a_tail, a_rdy;
    logic [1:0]      a_ext, a_osel;
    logic [DW-1:0]   a_odata;
    logic            a_ov, a_ot, a_ordy, a_lock;

    // DUT B: external select, 5 channels
    logic            b_rst;
    logic [NB*DW-1:0] b_data;
    logic [NB-1:0]   b_valid, b_tail, b_rdy;
    logic [2:0]      b_ext, b_osel;
    logic [DW-1:0]   b_odata;
    logic            b_ov, b_ot, b_ordy, b_lock;

    flit_arb_mux #(.DATA_WIDTH(DW), .IN_NUM(NA), .RR_MODE(1)) u_a (
        .clk(clk), .reset(a_rst), .in_data(a_data), .in_valid(a_valid), .in_tail(a_tail),
        .in_ready(a_rdy), .ext_sel(a_ext), .out_data(a_odata), .out_valid(a_ov),
        .out_tail(a_ot), .out_sel(a_osel), .out_ready(a_ordy), .locked(a_lock));

    flit_arb_mux #(.DATA_WIDTH(DW), .IN_NUM(NB), .RR_MODE(0)) u_b (
        .clk(clk), .reset(b_rst), .in_data(b_data), .in_valid(b_valid), .in_tail(b_tail),
        .in_ready(b_rdy), .ext_sel(b_ext), .out_data(b_odata), .out_valid(b_ov),
        .out_tail(b_ot), .out_sel(b_osel), .out_ready(b_ordy), .locked(b_lock));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int ch, input int row);
        return {8'(ch), 8'h5A, 16'(row)};
    endfunction

    typedef struct {
        logic [3:0] v;
        logic [3:0] t;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] sel;
        logic       lk;
        int         ld;
    } vec_t;

    typedef struct {
        logic [1:0]    sel;
        logic [DW-1:0] d;
        logic          t;
    } flit_t;

    vec_t  tbl[18];
    flit_t q[$];

    initial begin
        // all 1-flit packets, then a 3-flit packet on ch1, backpressure, lock on ch3 with bubbles
        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 2};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 3};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4};
        tbl[5]  = '{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 5};
        tbl[6]  = '{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 6};
        tbl[7]  = '{4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 7};
        tbl[8]  = '{4'b0111, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8};
        tbl[10] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8};
        tbl[11] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8};
        tbl[12] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 12};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, -1};
        tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 14};
        tbl[15] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 15};
        tbl[16] = '{4'b0111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, -1};
        tbl[17] = '{4'b0111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, -1};

        a_rst = 1'b1; a_valid = 4'b1111; a_tail = 4'b1111; a_ordy = 1'b1; a_ext = '0; a_data = '0;
        b_rst = 1'b1; b_valid = '0; b_tail = '0; b_ordy = 1'b1; b_ext = '0;
        for (int i = 0; i < NB; i++) b_data[i*DW +: DW] = 32'hB000_0000 + i;

        // reset with all channels valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", a_rdy, 4'b0000);
        chk("reset out_valid", a_ov, 0);
        chk("reset out_data", a_odata, 0);
        chk("reset out_tail", a_ot, 0);
        chk("reset out_sel", a_osel, 0);
        chk("reset locked", a_lock, 0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;

        for (int r = 0; r < 18; r++) begin
            a_valid = tbl[r].v;
            a_tail  = tbl[r].t;
            a_ordy  = tbl[r].ordy;
            for (int ch = 0; ch < NA; ch++) a_data[ch*DW +: DW] = pat(ch, r);
            @(negedge clk);
            chk($sformatf("row%0d in_ready", r), a_rdy, tbl[r].rdy);
            @(posedge clk); #1;
            chk($sformatf("row%0d out_valid", r), a_ov, tbl[r].ov);
            chk($sformatf("row%0d out_sel", r), a_osel, tbl[r].sel);
            chk($sformatf("row%0d locked", r), a_lock, tbl[r].lk);
            if (tbl[r].ld >= 0)
                chk($sformatf("row%0d out_data", r), a_odata, pat(tbl[r].sel, tbl[r].ld));
        end

        // reset mid-packet: locked ch3 now valid, reset must still block it
        a_rst = 1'b1; a_valid = 4'b1111;
        @(negedge clk);
        chk("midrst in_ready", a_rdy, 4'b0000);
        @(posedge clk); #1;
        chk("midrst locked", a_lock, 0);
        chk("midrst out_valid", a_ov, 0);
        chk("midrst out_sel", a_osel, 0);
        a_rst = 1'b0; a_valid = 4'b0101; a_tail = 4'b0101;
        @(negedge clk);
        chk("postrst rr_ptr in_ready", a_rdy, 4'b0001);
        @(posedge clk); #1;
        chk("postrst out_sel", a_osel, 0);
        chk("postrst out_valid", a_ov, 1);

        // external select on a 5-channel instance
        b_valid = 5'b11111; b_tail = 5'b11111; b_ext = 3'd2;
        @(negedge clk);
        chk("ext2 in_ready", b_rdy, 5'b00100);
        @(posedge clk); #1;
        chk("ext2 out_valid", b_ov, 1);
        chk("ext2 out_sel", b_osel, 2);
        chk("ext2 out_data", b_odata, 32'hB000_0002);
        b_ext = 3'd5;
        @(negedge clk);
        chk("ext5 in_ready", b_rdy, 5'b00000);
        @(posedge clk); #1;
        chk("ext5 out_valid", b_ov, 0);
        b_ext = 3'd4; b_tail = 5'b01111;
        @(negedge clk);
        chk("ext4 in_ready", b_rdy, 5'b10000);
        @(posedge clk); #1;
        chk("ext4 out_sel", b_osel, 4);
        chk("ext4 locked", b_lock, 1);
        b_ext = 3'd1; b_tail = 5'b11111;
        @(negedge clk);
        chk("extlock in_ready", b_rdy, 5'b10000);
        @(posedge clk); #1;
        chk("extlock out_sel", b_osel, 4);
        chk("extlock locked", b_lock, 0);
        @(negedge clk);
        chk("ext1 in_ready", b_rdy, 5'b00010);
        @(posedge clk); #1;

        // random traffic on DUT A against a packet-level scoreboard
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        begin
            logic       m_locked;
            int         m_lockch, m_ptr, g;
            logic       ld;
            logic [3:0] exp_rdy;
            m_locked = 1'b0; m_lockch = 0; m_ptr = 0;
            q.delete();
            for (int cyc = 0; cyc < 400; cyc++) begin
                for (int ch = 0; ch < NA; ch++) begin
                    a_valid[ch] = ($urandom_range(0, 9) < 7);
                    a_tail[ch]  = ($urandom_range(0, 2) == 0);
                    a_data[ch*DW +: DW] = $urandom;
                end
                a_ordy = ($urandom_range(0, 3) != 0);
                ld = (q.size() == 0) || a_ordy;
                g = -1;
                if (m_locked) begin
                    if (a_valid[m_lockch]) g = m_lockch;
                end else begin
                    for (int k = 0; k < NA; k++) begin
                        int j;
                        j = (m_ptr + k) % NA;
                        if (g < 0 && a_valid[j]) g = j;
                    end
                end
                if (!ld) g = -1;
                exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
                @(negedge clk);
                chk($sformatf("rnd%0d in_ready", cyc), a_rdy, exp_rdy);
                chk($sformatf("rnd%0d out_valid", cyc), a_ov, q.size() != 0);
                chk($sformatf("rnd%0d locked", cyc), a_lock, m_locked);
                if (q.size() != 0) begin
                    chk($sformatf("rnd%0d out_data", cyc), a_odata, q[0].d);
                    chk($sformatf("rnd%0d out_sel", cyc), a_osel, q[0].sel);
                    chk($sformatf("rnd%0d out_tail", cyc), a_ot, q[0].t);
                end
                @(posedge clk); #1;
                if (q.size() != 0 && a_ordy) void'(q.pop_front());
                if (g >= 0) begin
                    q.push_back('{2'(g), a_data[g*DW +: DW], a_tail[g]});
                    if (a_tail[g]) begin
                        m_locked = 1'b0;
                        m_ptr = (g + 1) % NA;
                    end else begin
                        m_locked = 1'b1;
                        m_lockch = g;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
